// File: rtl/binary_quiz_ctrl.sv
// Binary quiz game controller: random 4-bit target, debounced submit, judging and streak score.
// Optional answer time limit is built only when QUIZ_TIMEOUT_EN is defined.
module binary_quiz_ctrl #(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
    parameter logic [23:0] FEEDBACK_CYCLES = 24'd10000000,
    parameter logic [27:0] TIMEOUT_CYCLES  = 28'd150000000,
    parameter logic [7:0]  LFSR_SEED       = 8'hA5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] sw,
    input  logic       btn,
    output logic [3:0] digit,
    output logic       blank,
    output logic [1:0] result,
    output logic [3:0] score,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_NEW,
        S_ASK,
        S_CORRECT,
        S_WRONG
    } state_t;

    // An all-zero seed would lock the LFSR up
    localparam logic [7:0] SEED = (LFSR_SEED == 8'h00) ? 8'hA5 : LFSR_SEED;

    state_t      state_reg, state_next;
    logic [3:0]  sw_meta_reg, sw_sync_reg;
    logic        btn_meta_reg, btn_sync_reg;
    logic        btn_level_reg, btn_prev_reg;
    logic [15:0] deb_cnt_reg;
    logic [7:0]  lfsr_reg;
    logic [3:0]  target_reg, target_next;
    logic [3:0]  score_reg, score_next;
    logic [1:0]  result_reg, result_next;
    logic [23:0] fb_cnt_reg, fb_cnt_next;
    logic        submit;

`ifdef QUIZ_TIMEOUT_EN
    logic [27:0] timer_reg, timer_next;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

    // Input synchronisers, button debouncer and free-running LFSR
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_meta_reg   <= 4'd0;
            sw_sync_reg   <= 4'd0;
            btn_meta_reg  <= 1'b0;
            btn_sync_reg  <= 1'b0;
            btn_level_reg <= 1'b0;
            btn_prev_reg  <= 1'b0;
            deb_cnt_reg   <= 16'd0;
            lfsr_reg      <= SEED;
        end else begin
            sw_meta_reg  <= sw;
            sw_sync_reg  <= sw_meta_reg;
            btn_meta_reg <= btn;
            btn_sync_reg <= btn_meta_reg;
            btn_prev_reg <= btn_level_reg;
            if (btn_sync_reg != btn_level_reg) begin
                if (deb_cnt_reg == DEBOUNCE_CYCLES - 16'd1) begin
                    btn_level_reg <= btn_sync_reg;
                    deb_cnt_reg   <= 16'd0;
                end else begin
                    deb_cnt_reg <= deb_cnt_reg + 16'd1;
                end
            end else begin
                deb_cnt_reg <= 16'd0;
            end
            lfsr_reg <= {lfsr_reg[6:0], lfsr_reg[7] ^ lfsr_reg[5] ^ lfsr_reg[4] ^ lfsr_reg[3]};
        end
    end

    // Pulse lands in the cycle after the accepted level rises
    assign submit = btn_level_reg & ~btn_prev_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= S_IDLE;
            target_reg <= 4'd0;
            score_reg  <= 4'd0;
            result_reg <= 2'b00;
            fb_cnt_reg <= 24'd0;
`ifdef QUIZ_TIMEOUT_EN
            timer_reg  <= 28'd0;
`endif
        end else begin
            state_reg  <= state_next;
            target_reg <= target_next;
            score_reg  <= score_next;
            result_reg <= result_next;
            fb_cnt_reg <= fb_cnt_next;
`ifdef QUIZ_TIMEOUT_EN
            timer_reg  <= timer_next;
`endif
        end
    end

    always_comb begin
        state_next  = state_reg;
        target_next = target_reg;
        score_next  = score_reg;
        result_next = result_reg;
        fb_cnt_next = fb_cnt_reg;
`ifdef QUIZ_TIMEOUT_EN
        timer_next  = timer_reg;
`endif
        case (state_reg)
            S_IDLE: begin
                if (submit) state_next = S_NEW;
            end
            S_NEW: begin
                // target_reg still holds the previous round's target here
                if (lfsr_reg[3:0] == target_reg) target_next = lfsr_reg[3:0] + 4'd1;
                else                             target_next = lfsr_reg[3:0];
                result_next = 2'b00;
                fb_cnt_next = 24'd0;
`ifdef QUIZ_TIMEOUT_EN
                timer_next  = 28'd0;
`endif
                state_next  = S_ASK;
            end
            S_ASK: begin
                if (submit) begin
                    if (sw_sync_reg == target_reg) begin
                        state_next  = S_CORRECT;
                        result_next = 2'b01;
                        score_next  = (score_reg == 4'd15) ? 4'd15 : score_reg + 4'd1;
                    end else begin
                        state_next  = S_WRONG;
                        result_next = 2'b10;
                        score_next  = 4'd0;
                    end
`ifdef QUIZ_TIMEOUT_EN
                end else if (timer_reg == TIMEOUT_CYCLES - 28'd1) begin
                    state_next  = S_WRONG;
                    result_next = 2'b11;
                    score_next  = 4'd0;
                end else begin
                    timer_next = timer_reg + 28'd1;
`endif
                end
            end
            S_CORRECT, S_WRONG: begin
                if (fb_cnt_reg == FEEDBACK_CYCLES - 24'd1) begin
                    state_next  = S_NEW;
                    result_next = 2'b00;
                    fb_cnt_next = 24'd0;
                end else begin
                    fb_cnt_next = fb_cnt_reg + 24'd1;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign digit  = (state_reg == S_IDLE) ? 4'd0 : target_reg;
    assign blank  = (state_reg == S_IDLE);
    assign busy   = (state_reg == S_CORRECT) || (state_reg == S_WRONG);
    assign result = result_reg;
    assign score  = score_reg;

endmodule

// File: tb/tb_binary_quiz_ctrl.sv
// Scoreboard bench for binary_quiz_ctrl: stimulus queues expected judgements, a monitor checks them.
module tb_binary_quiz_ctrl;

    logic       clk;
    logic       rst_n;
    logic [3:0] sw;
    logic       btn;
    logic [3:0] digit;
    logic       blank;
    logic [1:0] result;
    logic [3:0] score;
    logic       busy;

    binary_quiz_ctrl #(
        .DEBOUNCE_CYCLES(16'd4),
        .FEEDBACK_CYCLES(24'd8),
        .TIMEOUT_CYCLES (28'd32),
        .LFSR_SEED      (8'hA5)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sw    (sw),
        .btn   (btn),
        .digit (digit),
        .blank (blank),
        .result(result),
        .score (score),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] res;
        logic [3:0] scr;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   exp_score = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference LFSR, x^8+x^6+x^5+x^4+1, seeded 0xA5
    logic [7:0] m_lfsr;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_lfsr <= 8'hA5;
        else        m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end

    // Monitor: judgement scoreboard, feedback length, new-target prediction
    logic       prev_blank, prev_busy, tgt_pending;
    logic [1:0] prev_result;
    logic [3:0] tgt_exp, tgt_old, m_prev_tgt;
    int         busy_len;
    exp_t       e_mon;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_blank  = 1'b1;
            prev_busy   = 1'b0;
            prev_result = 2'b00;
            busy_len    = 0;
            tgt_pending = 1'b0;
            m_prev_tgt  = 4'd0;
        end else begin
            if (tgt_pending) begin
                check("ask_digit", {28'd0, digit}, {28'd0, tgt_exp});
                check("ask_digit_differs", {31'd0, digit != tgt_old}, 32'd1);
                check("ask_blank", {31'd0, blank}, 32'd0);
                tgt_pending = 1'b0;
            end
            if ((prev_blank && !blank) || (prev_busy && !busy)) begin
                if (prev_busy) check("busy_len", busy_len, 32'd8);
                check("new_result", {30'd0, result}, 32'd0);
                tgt_old = m_prev_tgt;
                tgt_exp = (m_lfsr[3:0] == m_prev_tgt) ? m_lfsr[3:0] + 4'd1 : m_lfsr[3:0];
                m_prev_tgt  = tgt_exp;
                tgt_pending = 1'b1;
            end
            if (busy) busy_len++;
            else      busy_len = 0;
            if (prev_result == 2'b00 && result != 2'b00) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_round: got result=%0d score=%0d, required no round (t=%0t)",
                             result, score, $time);
                end else begin
                    e_mon = exp_q.pop_front();
                    $display("round: result=%0d score=%0d (required %0d/%0d)", result, score, e_mon.res, e_mon.scr);
                    check("round_result", {30'd0, result}, {30'd0, e_mon.res});
                    check("round_score", {28'd0, score}, {28'd0, e_mon.scr});
                    check("round_busy", {31'd0, busy}, 32'd1);
                end
            end
            prev_blank  = blank;
            prev_busy   = busy;
            prev_result = result;
        end
    end

    task automatic press(input int hold);
        btn = 1'b1;
        repeat (hold) @(negedge clk);
        btn = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic wait_ask();
        int k;
        k = 0;
        while ((blank || busy) && k < 300) begin
            @(negedge clk);
            k++;
        end
        if (k >= 300) check("wait_ask_timeout", 32'd1, 32'd0);
        repeat (2) @(negedge clk);
    endtask

    task automatic answer(input bit good);
        exp_t e;
        sw = good ? digit : (digit ^ 4'h1);
        exp_score = good ? ((exp_score == 15) ? 15 : exp_score + 1) : 0;
        e.res = good ? 2'b01 : 2'b10;
        e.scr = exp_score[3:0];
        exp_q.push_back(e);
        repeat (3) @(negedge clk);
        press(8);
        wait_ask();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, required finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        int   k;
        int   bad;
        exp_t e;
        rst_n = 1'b0;
        btn   = 1'b0;
        sw    = 4'd0;

        // 1: reset held while the button chatters
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("reset_outputs", {20'd0, digit, blank, result, score, busy},
                  {20'd0, 4'd0, 1'b1, 2'd0, 4'd0, 1'b0});
            btn = ~btn;
        end
        btn = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("idle_after_reset", {29'd0, blank, busy, |digit}, {29'd0, 1'b1, 1'b0, 1'b0});

        // 2: short press is rejected, long press starts a round
        btn = 1'b1;
        repeat (3) @(negedge clk);
        btn = 1'b0;
        repeat (12) @(negedge clk);
        check("short_press_ignored", {31'd0, blank}, 32'd1);
        press(6);
        wait_ask();
        check("ask_after_press", {29'd0, blank, busy, 1'b0}, 32'd0);

        // 3/4: correct answers then a wrong one
        answer(1'b1);
        answer(1'b1);
        answer(1'b1);
        check("score_three", {28'd0, score}, 32'd3);
        answer(1'b0);

        // 5: saturation over 17 correct answers
        for (int i = 0; i < 17; i++) answer(1'b1);
        check("score_saturated", {28'd0, score}, 32'd15);

        // 5: chatter during feedback must not start another round
        sw = digit;
        e.res = 2'b01;
        e.scr = 4'd15;
        exp_q.push_back(e);
        repeat (3) @(negedge clk);
        btn = 1'b1;
        repeat (6) @(negedge clk);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            btn = ~btn;
        end
        btn = 1'b0;
        repeat (8) @(negedge clk);
        wait_ask();
        repeat (15) @(negedge clk);
        check("drop_score", {28'd0, score}, 32'd15);
        check("drop_no_round", {29'd0, result, busy}, 32'd0);

        // 6: asynchronous reset during CORRECT
        sw = digit;
        e.res = 2'b01;
        e.scr = 4'd15;
        exp_q.push_back(e);
        repeat (3) @(negedge clk);
        btn = 1'b1;
        k = 0;
        while (!busy && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("reached_correct", {31'd0, busy}, 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        check("midreset_outputs", {20'd0, digit, blank, result, score, busy},
              {20'd0, 4'd0, 1'b1, 2'd0, 4'd0, 1'b0});
        exp_score = 0;
        btn = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("idle_after_midreset", {27'd0, blank, score}, {27'd0, 1'b1, 4'd0});

        // 6: answer time limit
        press(6);
        wait_ask();
        answer(1'b1);
`ifdef QUIZ_TIMEOUT_EN
        exp_score = 0;
        e.res = 2'b11;
        e.scr = 4'd0;
        exp_q.push_back(e);
        k = 0;
        while (result == 2'b00 && k < 60) begin
            @(negedge clk);
            k++;
        end
        check("timeout_seen", {30'd0, result}, 32'd3);
        repeat (2) @(negedge clk);
`else
        bad = 0;
        repeat (1100) begin
            @(negedge clk);
            if (result != 2'b00 || busy || blank) bad++;
        end
        check("ask_persists_bad_cycles", bad, 32'd0);
        check("ask_persists_score", {28'd0, score}, 32'd1);
`endif
        check("queue_drained", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/binary_quiz_ctrl.md
Name: binary_quiz_ctrl

Overview:
Game controller for the DIP-switch binary quiz, directly upstream of the seven-segment decoder. It picks a pseudo-random 4-bit target and drives it as the digit the player must enter in binary on the switches. It debounces the submit button, judges the answer and keeps a score.

Parameters:
DEBOUNCE_CYCLES, 16'd50000, consecutive stable samples needed before a button level change is accepted (min 1).
FEEDBACK_CYCLES, 24'd10000000, length of the correct/wrong feedback phase in clock cycles (min 1).
TIMEOUT_CYCLES, 28'd150000000, answer time limit; used only when QUIZ_TIMEOUT_EN is defined.
LFSR_SEED, 8'hA5, LFSR reset value; a value of 0 is replaced by 8'hA5.

Ports:
clk  input  1  system clock; all state on rising edge.
rst_n  input  1  reset; asynchronous, active-low.
sw  input  4  player answer from the DIP switches; sampled through a 2-FF synchroniser.
btn  input  1  raw submit button, active-high, asynchronous, bouncy.
digit  output  4  target value for the seven-segment decoder.
blank  output  1  1 = display should be dark (IDLE).
result  output  2  00 none, 01 correct, 10 wrong, 11 timeout.
score  output  4  current streak, saturating at 15.
busy  output  1  1 while in the feedback phase (CORRECT/WRONG).

Behaviour:
- Reset values: digit=0, blank=1, result=00, score=0, busy=0, state=IDLE, lfsr=LFSR_SEED, counters=0, synchronisers=0, prev_target=0.
- btn path: 2-FF synchroniser, then debounce counter.
  - Accepted level changes only after DEBOUNCE_CYCLES consecutive equal synchronised samples that differ from the current level.
  - Any differing sample restarts the count.
  - A 0->1 change of the accepted level produces a 1-cycle submit pulse; 1->0 produces nothing.
- sw path: 2-FF synchronised; the synchronised value is used for comparison.
- LFSR: 8-bit Fibonacci, polynomial x^8+x^6+x^5+x^4+1, shifts every cycle in all states. Never 0.
- FSM:
  - IDLE: blank=1, digit=0. On submit pulse -> NEW.
  - NEW (1 cycle): target = lfsr[3:0]; if equal to prev_target, target = lfsr[3:0]+1 mod 16. Store as prev_target. result=00. -> ASK.
  - ASK: blank=0, digit=target, result=00. On submit pulse at cycle N:
    - if sw_sync==target: -> CORRECT, score+1 (saturate at 15).
    - otherwise: -> WRONG, score=0.
    - result is valid at N+1.
  - CORRECT / WRONG: busy=1, digit holds target, result=01/10. Feedback counter runs FEEDBACK_CYCLES cycles, then -> NEW.
- Submit pulses in NEW, CORRECT or WRONG are dropped, not queued.
- Submit and the debounce update in the same cycle: the pulse is generated in the cycle after the level is accepted.
- Reset asserted mid-round: all outputs return to reset values immediately (asynchronous). After release the FSM restarts in IDLE.
- The target sequence is deterministic for a given LFSR_SEED and the cycle count since reset.

Optional Feature:
QUIZ_TIMEOUT_EN
- Defined: ASK runs a timer cleared on ASK entry. After TIMEOUT_CYCLES cycles with no submit -> WRONG with result=11 and score=0.
  - A submit in the same cycle the timer expires takes priority and is judged normally.
- Not defined: no timer logic is built, ASK waits indefinitely, result never shows 11, and TIMEOUT_CYCLES is ignored.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4, FEEDBACK_CYCLES=8, TIMEOUT_CYCLES=32.
1. Reset: hold rst_n=0 with btn toggling -> digit=0, blank=1, result=00, score=0, busy=0 throughout. After release, state stays IDLE.
2. Debounce:
   - btn high for 3 cycles, then low -> no transition, blank stays 1.
   - btn high for 6 cycles -> exactly one submit. blank=0 and digit=lfsr-derived target 2 cycles after the pulse.
3. Correct answer: set sw=digit and press -> result=01 and busy=1 for 8 cycles, score=1. Then a new digit appears that differs from the previous one; result returns to 00.
4. Wrong answer after 3 correct: set sw=digit^4'h1 and press -> result=10, score goes from 3 to 0, busy for 8 cycles.
5. Saturation and drops:
   - 17 consecutive correct answers -> score reads 15 after the 15th, 16th and 17th.
   - Presses during busy are ignored: score unchanged, no extra round.
6. Reset mid-feedback and timeout:
   - Assert rst_n low during CORRECT -> all outputs return to reset values in the same cycle.
   - With QUIZ_TIMEOUT_EN, no press in ASK for 32 cycles -> result=11, score=0.
   - Without QUIZ_TIMEOUT_EN, ASK persists for more than 1000 cycles.
